// File: rtl/scarv_cop_cprs_param.sv
// scarv_cop_cprs_param
//   Parametrised COP general-purpose register file: NREGS x XLEN storage,
//   NRPORTS combinational read ports, one byte-lane-masked write port,
//   optional same-cycle write->read forwarding, and an init sequencer that
//   zeroes every register, one per cycle, while cprs_init is held high.
//   Storage has no reset; contents are defined only after init or a write.

module scarv_cop_cprs_param #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned NREGS   = 16,
   parameter int unsigned NRPORTS = 3,
   parameter int unsigned BYPASS  = 0
) (
   input  logic                              g_clk,
   input  logic                              g_reset,
   output logic                              g_clk_req,

   input  logic                              cprs_init,
   output logic                              cprs_init_busy,
   output logic                              cprs_init_done,

   input  logic [NRPORTS-1:0]                crs_ren,
   input  logic [NRPORTS*$clog2(NREGS)-1:0]  crs_addr,
   output logic [NRPORTS*XLEN-1:0]           crs_rdata,

   input  logic [XLEN/8-1:0]                 crd_wen,
   input  logic [$clog2(NREGS)-1:0]          crd_addr,
   input  logic [XLEN-1:0]                   crd_wdata
);

   localparam int unsigned   NB   = XLEN / 8;
   localparam int unsigned   AW   = $clog2(NREGS);
   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t          state;
   logic [AW-1:0]   cnt;
   logic [XLEN-1:0] regs [NREGS];

   logic            wr_acc;
   logic            clr_en;

   // Write port is only live in IDLE with no init request; nothing is written
   // to storage in a reset cycle, by either the write port or the sequencer.
   assign wr_acc = (state == ST_IDLE)  &&  !cprs_init && !g_reset;
   assign clr_en = (state == ST_CLEAR) &&   cprs_init && !g_reset;

   assign g_clk_req = (|crd_wen) | cprs_init | (state != ST_IDLE);

   // Init sequencer: walks cnt over every register, aborts if cprs_init drops.
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         cprs_init_busy <= 1'b0;
         cprs_init_done <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cprs_init) begin
                  state          <= ST_CLEAR;
                  cnt            <= '0;
                  cprs_init_busy <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (!cprs_init) begin
                  state          <= ST_IDLE;
                  cprs_init_busy <= 1'b0;
               end else if (cnt == LAST) begin
                  state          <= ST_DONE;
                  cprs_init_busy <= 1'b0;
                  cprs_init_done <= 1'b1;
               end else begin
                  cnt <= cnt + AW'(1);
               end
            end
            ST_DONE: begin
               if (!cprs_init) begin
                  state          <= ST_IDLE;
                  cprs_init_done <= 1'b0;
               end
            end
            default: begin
               state          <= ST_IDLE;
               cprs_init_busy <= 1'b0;
               cprs_init_done <= 1'b0;
            end
         endcase
      end
   end

   // Storage update: init clear of reg[cnt], otherwise lane-masked write.
   always_ff @(posedge g_clk) begin
      if (clr_en) begin
         regs[cnt] <= '0;
      end else if (wr_acc) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (crd_wen[b]) begin
               regs[crd_addr][b*8 +: 8] <= crd_wdata[b*8 +: 8];
            end
         end
      end
   end

   // Read ports: combinational, zero when disabled, optional lane forwarding.
   always_comb begin : rd_mux
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rd;
      crs_rdata = '0;
      ra        = '0;
      rd        = '0;
      for (int unsigned p = 0; p < NRPORTS; p++) begin
         ra = crs_addr[p*AW +: AW];
         rd = regs[ra];
         if ((BYPASS != 0) && wr_acc && (crd_addr == ra)) begin
            for (int unsigned b = 0; b < NB; b++) begin
               if (crd_wen[b]) begin
                  rd[b*8 +: 8] = crd_wdata[b*8 +: 8];
               end
            end
         end
         if (crs_ren[p]) begin
            crs_rdata[p*XLEN +: XLEN] = rd;
         end
      end
   end

endmodule

// File: tb/tb_scarv_cop_cprs_param.sv
// tb_scarv_cop_cprs_param
//   Directed bench: two 32x16x3 instances (BYPASS=0 / BYPASS=1) driven with
//   identical stimulus, plus one 64x32x4 BYPASS=1 instance.

module tb_scarv_cop_cprs_param;

   logic g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   logic        g_reset;
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // 32-bit / 16-reg / 3-port stimulus, shared by dut_a0 and dut_a1
   logic        a_init;
   logic [2:0]  a_ren;
   logic [11:0] a_addr;
   logic [3:0]  a_wen;
   logic [3:0]  a_waddr;
   logic [31:0] a_wdata;
   logic [95:0] a0_rdata, a1_rdata;
   logic        a0_busy, a0_done, a0_req;
   logic        a1_busy, a1_done, a1_req;

   // 64-bit / 32-reg / 4-port stimulus
   logic         c_init;
   logic [3:0]   c_ren;
   logic [19:0]  c_addr;
   logic [7:0]   c_wen;
   logic [4:0]   c_waddr;
   logic [63:0]  c_wdata;
   logic [255:0] c_rdata;
   logic         c_busy, c_done, c_req;

   scarv_cop_cprs_param #(.XLEN(32), .NREGS(16), .NRPORTS(3), .BYPASS(0)) dut_a0 (
      .g_clk(g_clk), .g_reset(g_reset), .g_clk_req(a0_req),
      .cprs_init(a_init), .cprs_init_busy(a0_busy), .cprs_init_done(a0_done),
      .crs_ren(a_ren), .crs_addr(a_addr), .crs_rdata(a0_rdata),
      .crd_wen(a_wen), .crd_addr(a_waddr), .crd_wdata(a_wdata)
   );

   scarv_cop_cprs_param #(.XLEN(32), .NREGS(16), .NRPORTS(3), .BYPASS(1)) dut_a1 (
      .g_clk(g_clk), .g_reset(g_reset), .g_clk_req(a1_req),
      .cprs_init(a_init), .cprs_init_busy(a1_busy), .cprs_init_done(a1_done),
      .crs_ren(a_ren), .crs_addr(a_addr), .crs_rdata(a1_rdata),
      .crd_wen(a_wen), .crd_addr(a_waddr), .crd_wdata(a_wdata)
   );

   scarv_cop_cprs_param #(.XLEN(64), .NREGS(32), .NRPORTS(4), .BYPASS(1)) dut_c (
      .g_clk(g_clk), .g_reset(g_reset), .g_clk_req(c_req),
      .cprs_init(c_init), .cprs_init_busy(c_busy), .cprs_init_done(c_done),
      .crs_ren(c_ren), .crs_addr(c_addr), .crs_rdata(c_rdata),
      .crd_wen(c_wen), .crd_addr(c_waddr), .crd_wdata(c_wdata)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge g_clk);
      #1;
   endtask

   function automatic logic [31:0] a0p(input int p);
      return a0_rdata[p*32 +: 32];
   endfunction

   function automatic logic [31:0] a1p(input int p);
      return a1_rdata[p*32 +: 32];
   endfunction

   function automatic logic [63:0] cp(input int p);
      return c_rdata[p*64 +: 64];
   endfunction

   task automatic a_write(input logic [3:0] addr, input logic [31:0] d);
      a_wen = 4'hF; a_waddr = addr; a_wdata = d;
      step();
      a_wen = 4'h0;
   endtask

   task automatic c_write(input logic [4:0] addr, input logic [63:0] d);
      c_wen = 8'hFF; c_waddr = addr; c_wdata = d;
      step();
      c_wen = 8'h00;
   endtask

   // read reg r through port 0 of both A instances and compare
   task automatic a_expect(input string tag, input logic [3:0] r, input logic [31:0] exp);
      a_ren = 3'b001; a_addr[3:0] = r;
      #1;
      check($sformatf("%s_a0_r%0d", tag, r), 64'(a0p(0)), 64'(exp));
      check($sformatf("%s_a1_r%0d", tag, r), 64'(a1p(0)), 64'(exp));
   endtask

   task automatic c_expect(input string tag, input logic [4:0] r, input logic [63:0] exp);
      c_ren = 4'b0001; c_addr[4:0] = r;
      #1;
      check($sformatf("%s_c_r%0d", tag, r), cp(0), exp);
   endtask

   initial begin
      g_reset = 1'b1;
      a_init = 0; a_ren = '0; a_addr = '0; a_wen = '0; a_waddr = '0; a_wdata = '0;
      c_init = 0; c_ren = '0; c_addr = '0; c_wen = '0; c_waddr = '0; c_wdata = '0;
      step(); step();
      g_reset = 1'b0;
      #1;

      // reset state
      check("rst_busy", 64'(a0_busy), 64'd0);
      check("rst_done", 64'(a0_done), 64'd0);
      check("rst_req",  64'(a0_req),  64'd0);
      check("rst_c_busy", 64'(c_busy), 64'd0);

      // 1: full init, busy 16 cycles, done on 17th; writes during CLEAR dropped
      a_init = 1'b1;
      #1;
      check("init_req", 64'(a0_req), 64'd1);
      for (int k = 1; k <= 17; k++) begin
         step();
         if (k == 6) a_wen = 4'h0;
         check($sformatf("init_busy_k%0d", k), 64'(a0_busy), 64'(k <= 16));
         check($sformatf("init_done_k%0d", k), 64'(a0_done), 64'(k == 17));
         if (k == 5) begin
            a_wen = 4'hF; a_waddr = 4'd0; a_wdata = 32'hDEADBEEF;
            a_ren = 3'b001; a_addr = '0;
            #1;
            check("init_no_bypass", 64'(a1p(0)), 64'd0);
         end
      end
      check("init_b_busy", 64'(a1_busy), 64'd0);
      check("init_b_done", 64'(a1_done), 64'd1);
      step();
      check("done_hold", 64'(a0_done), 64'd1);
      for (int r = 0; r < 16; r++) begin
         a_ren = 3'b111;
         for (int p = 0; p < 3; p++) a_addr[p*4 +: 4] = r[3:0];
         #1;
         for (int p = 0; p < 3; p++)
            check($sformatf("zero_r%0d_p%0d", r, p), 64'(a0p(p)), 64'd0);
      end
      a_init = 1'b0;
      step();
      check("idle_done", 64'(a0_done), 64'd0);
      check("idle_busy", 64'(a0_busy), 64'd0);

      // 2: lane-masked write onto zero
      a_ren = 3'b001; a_addr = 12'h003;
      a_wen = 4'b0101; a_waddr = 4'd3; a_wdata = 32'hAABBCCDD;
      #1;
      check("wen_req",      64'(a0_req), 64'd1);
      check("lane_nobyp",   64'(a0p(0)), 64'd0);
      check("lane_byp",     64'(a1p(0)), 64'h00BB00DD);
      step();
      a_wen = 4'h0;
      #1;
      check("lane_a0", 64'(a0p(0)), 64'h00BB00DD);
      check("lane_a1", 64'(a1p(0)), 64'h00BB00DD);

      // 3: same-cycle forwarding to ports 0 and 2 only
      a_ren = 3'b111; a_addr = {4'd5, 4'd3, 4'd5};
      a_wen = 4'hF; a_waddr = 4'd5; a_wdata = 32'h12345678;
      #1;
      check("byp0_off", 64'(a0p(0)), 64'd0);
      check("byp2_off", 64'(a0p(2)), 64'd0);
      check("byp0_on",  64'(a1p(0)), 64'h12345678);
      check("byp2_on",  64'(a1p(2)), 64'h12345678);
      check("byp1_other", 64'(a1p(1)), 64'h00BB00DD);
      step();
      a_wen = 4'h0;
      #1;
      check("byp_stored", 64'(a0p(0)), 64'h12345678);

      // 4: disabled read port returns zero
      a_write(4'd7, 32'hFFFFFFFF);
      a_ren = 3'b101; a_addr = {4'd0, 4'd7, 4'd0};
      #1;
      check("ren0_a0", 64'(a0p(1)), 64'd0);
      check("ren0_a1", 64'(a1p(1)), 64'd0);
      a_ren = 3'b010;
      #1;
      check("ren1_a0", 64'(a0p(1)), 64'hFFFFFFFF);

      // 5: aborted init clears only regs 0..3
      a_write(4'd2, 32'h11111111);
      a_write(4'd4, 32'h22222222);
      a_write(4'd9, 32'h5A5A5A5A);
      a_init = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         check($sformatf("abort_busy_k%0d", k), 64'(a0_busy), 64'd1);
         check($sformatf("abort_done_k%0d", k), 64'(a0_done), 64'd0);
      end
      a_init = 1'b0;
      step();
      check("abort_idle_busy", 64'(a0_busy), 64'd0);
      check("abort_idle_done", 64'(a0_done), 64'd0);
      check("abort_idle_req",  64'(a0_req),  64'd0);
      a_expect("abort", 4'd0, 32'h0);
      a_expect("abort", 4'd2, 32'h0);
      a_expect("abort", 4'd3, 32'h0);
      a_expect("abort", 4'd4, 32'h22222222);
      a_expect("abort", 4'd9, 32'h5A5A5A5A);

      // 6: reset mid-CLEAR (cnt=8), reg8 survives the reset cycle, then re-init
      a_write(4'd8, 32'h88888888);
      a_init = 1'b1;
      for (int k = 1; k <= 9; k++) step();
      check("mid_busy", 64'(a0_busy), 64'd1);
      g_reset = 1'b1;
      step();
      g_reset = 1'b0;
      check("mrst_busy", 64'(a0_busy), 64'd0);
      check("mrst_done", 64'(a0_done), 64'd0);
      a_expect("mrst", 4'd8, 32'h88888888);
      a_expect("mrst", 4'd9, 32'h5A5A5A5A);
      a_expect("mrst", 4'd7, 32'h0);
      for (int k = 1; k <= 17; k++) begin
         step();
         check($sformatf("reinit_busy_k%0d", k), 64'(a0_busy), 64'(k <= 16));
         check($sformatf("reinit_done_k%0d", k), 64'(a0_done), 64'(k == 17));
      end
      a_expect("reinit", 4'd8, 32'h0);
      a_expect("reinit", 4'd9, 32'h0);
      a_init = 1'b0;
      step();

      // 64-bit / 32-reg / 4-port instance
      c_write(5'd31, 64'h0123456789ABCDEF);
      c_expect("c_pre", 5'd31, 64'h0123456789ABCDEF);
      c_init = 1'b1;
      for (int k = 1; k <= 33; k++) begin
         step();
         check($sformatf("c_busy_k%0d", k), 64'(c_busy), 64'(k <= 32));
         check($sformatf("c_done_k%0d", k), 64'(c_done), 64'(k == 33));
      end
      for (int r = 0; r < 32; r++) begin
         c_ren = 4'hF;
         for (int p = 0; p < 4; p++) c_addr[p*5 +: 5] = r[4:0];
         #1;
         for (int p = 0; p < 4; p++)
            check($sformatf("c_zero_r%0d_p%0d", r, p), cp(p), 64'd0);
      end
      c_init = 1'b0;
      step();

      c_ren = 4'b0101; c_addr = {5'd0, 5'd5, 5'd5, 5'd5};
      c_wen = 8'h81; c_waddr = 5'd5; c_wdata = 64'hFFEEDDCCBBAA9988;
      #1;
      check("c_byp_p0",  cp(0), 64'hFF00000000000088);
      check("c_byp_p2",  cp(2), 64'hFF00000000000088);
      check("c_ren0_p1", cp(1), 64'd0);
      step();
      c_wen = 8'h00;
      c_expect("c_lane", 5'd5, 64'hFF00000000000088);

      c_write(5'd8, 64'h8888888888888888);
      c_init = 1'b1;
      for (int k = 1; k <= 9; k++) step();
      check("c_mid_busy", 64'(c_busy), 64'd1);
      g_reset = 1'b1;
      step();
      g_reset = 1'b0;
      check("c_mrst_busy", 64'(c_busy), 64'd0);
      check("c_mrst_done", 64'(c_done), 64'd0);
      c_expect("c_mrst", 5'd8, 64'h8888888888888888);
      for (int k = 1; k <= 33; k++) begin
         step();
         check($sformatf("c_reinit_busy_k%0d", k), 64'(c_busy), 64'(k <= 32));
         check($sformatf("c_reinit_done_k%0d", k), 64'(c_done), 64'(k == 33));
      end
      c_expect("c_reinit", 5'd8, 64'd0);
      c_expect("c_reinit", 5'd5, 64'd0);
      c_init = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
